// File: rtl/mem_interface_multi.sv
// Memory-side stage of the multicycle core: drives a unified 1-cycle-latency RAM
// and holds the IR and MDR, with RV32I load/store sizing and alignment checks.
module mem_interface_multi #(
    parameter int unsigned ADDR_W    = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [ADDR_W-1:0] iPC,
    input  logic [ADDR_W-1:0] iALUOut,
    input  logic [31:0]       iRegB,
    input  logic [2:0]        iFunct3,
    input  logic              iIouD,
    input  logic              iMemRead,
    input  logic              iMemWrite,
    input  logic              iEscreveIR,
    input  logic [31:0]       iMemRData,
    output logic [ADDR_W-3:0] oMemAddr,
    output logic [31:0]       oMemWData,
    output logic [3:0]        oMemBE,
    output logic              oMemWE,
    output logic              oMemRE,
    output logic [31:0]       oIR,
    output logic [31:0]       oMDR,
    output logic              oBusy,
    output logic              oMisaligned
);

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    logic [ADDR_W-1:0] addr;
    logic [1:0]        off;
    size_t             size;
    logic              misal;
    logic              prevRd, prevWr;
    logic              rdEdge, wrEdge;
    logic              rdIssue, wrIssue;
    logic              pendValid, pendIR;
    logic [1:0]        pendOff;
    logic [2:0]        pendFunct3;
    logic [31:0]       irReg, mdrReg;
    logic [7:0]        loadByte;
    logic [15:0]       loadHalf;
    logic [31:0]       loadVal;

    assign addr     = iIouD ? iALUOut : iPC;
    assign off      = addr[1:0];
    assign oMemAddr = addr[ADDR_W-1:2];

    always_comb begin
        size = SZ_WORD;
        if (iIouD) begin
            unique case (iFunct3[1:0])
                2'b00:   size = SZ_BYTE;
                2'b01:   size = SZ_HALF;
                default: size = SZ_WORD;
            endcase
        end
    end

    assign misal = ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));

    // Only the first cycle of a held strobe issues; reset masks every request.
    assign wrEdge  = iRST & iMemWrite & ~prevWr;
    assign rdEdge  = iRST & iMemRead & ~prevRd;
    assign wrIssue = wrEdge & ~misal;
    assign rdIssue = rdEdge & ~wrEdge & ~misal;

    assign oMemWE      = wrIssue;
    assign oMemRE      = rdIssue;
    assign oMisaligned = (wrEdge | rdEdge) & misal;

    always_comb begin
        oMemBE    = '0;
        oMemWData = '0;
        if (wrIssue) begin
            unique case (size)
                SZ_BYTE: begin
                    oMemBE    = 4'b0001 << off;
                    oMemWData = {4{iRegB[7:0]}};
                end
                SZ_HALF: begin
                    oMemBE    = 4'b0011 << off;
                    oMemWData = {2{iRegB[15:0]}};
                end
                default: begin
                    oMemBE    = 4'b1111;
                    oMemWData = iRegB;
                end
            endcase
        end
    end

    always_comb begin
        loadByte = iMemRData[{pendOff, 3'b000} +: 8];
        loadHalf = pendOff[1] ? iMemRData[31:16] : iMemRData[15:0];
        unique case (pendFunct3)
            3'b000:  loadVal = {{24{loadByte[7]}}, loadByte};
            3'b001:  loadVal = {{16{loadHalf[15]}}, loadHalf};
            3'b100:  loadVal = {24'h000000, loadByte};
            3'b101:  loadVal = {16'h0000, loadHalf};
            default: loadVal = iMemRData;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            prevRd     <= 1'b0;
            prevWr     <= 1'b0;
            pendValid  <= 1'b0;
            pendIR     <= 1'b0;
            pendOff    <= '0;
            pendFunct3 <= '0;
            irReg      <= NOP_INSTR;
            mdrReg     <= '0;
        end else begin
            prevRd    <= iMemRead;
            prevWr    <= iMemWrite;
            pendValid <= rdIssue;
            if (rdIssue) begin
                pendIR     <= iEscreveIR & ~iIouD;
                pendOff    <= off;
                // Instruction-side reads are always full words, whatever funct3 holds.
                pendFunct3 <= iIouD ? iFunct3 : 3'b010;
            end
            if (pendValid) begin
                if (pendIR) begin
                    irReg <= iMemRData;
                end else begin
                    mdrReg <= loadVal;
                end
            end
        end
    end

    assign oIR   = irReg;
    assign oMDR  = mdrReg;
    assign oBusy = pendValid;

endmodule

// File: tb/tb_mem_interface_multi.sv
// Random and directed stimulus for mem_interface_multi against a behavioural
// model of the access rules plus a bench-side RAM.
module tb_mem_interface_multi;

    localparam int unsigned ADDR_W = 32;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic              iCLK = 1'b0;
    logic              iRST;
    logic [ADDR_W-1:0] iPC, iALUOut;
    logic [31:0]       iRegB;
    logic [31:0]       iMemRData = '0;
    logic [2:0]        iFunct3;
    logic              iIouD, iMemRead, iMemWrite, iEscreveIR;
    logic [ADDR_W-3:0] oMemAddr;
    logic [31:0]       oMemWData, oIR, oMDR;
    logic [3:0]        oMemBE;
    logic              oMemWE, oMemRE, oBusy, oMisaligned;

    int unsigned nChecks = 0;
    int unsigned nPass   = 0;

    logic [31:0] ram [0:255];
    logic [31:0] mdl [0:255];

    // Model state
    logic [31:0] mIR, mMDR, mPendWord;
    logic        mPrevRd, mPrevWr, mPend, mPendIR, mPendFull;
    int unsigned mPendOff;
    logic [2:0]  mPendF3;

    // DUT outputs seen during the most recent cycle
    logic        sRE, sWE, sMis, sBusy;
    logic [3:0]  sBE;
    logic [31:0] sWD, sAddr, sIR;

    always #5 iCLK = ~iCLK;

    mem_interface_multi #(
        .ADDR_W   (ADDR_W),
        .NOP_INSTR(NOP)
    ) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iPC        (iPC),
        .iALUOut    (iALUOut),
        .iRegB      (iRegB),
        .iFunct3    (iFunct3),
        .iIouD      (iIouD),
        .iMemRead   (iMemRead),
        .iMemWrite  (iMemWrite),
        .iEscreveIR (iEscreveIR),
        .iMemRData  (iMemRData),
        .oMemAddr   (oMemAddr),
        .oMemWData  (oMemWData),
        .oMemBE     (oMemBE),
        .oMemWE     (oMemWE),
        .oMemRE     (oMemRE),
        .oIR        (oIR),
        .oMDR       (oMDR),
        .oBusy      (oBusy),
        .oMisaligned(oMisaligned)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mdlLoad(input logic [31:0] w, input int unsigned off,
                                            input logic [2:0] f3, input logic full);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        if (full) return w;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFFFF00) : b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic resetModel();
        mIR     = NOP;
        mMDR    = '0;
        mPrevRd = 1'b0;
        mPrevWr = 1'b0;
        mPend   = 1'b0;
    endtask

    // Called at the falling edge once inputs are driven; checks this cycle, then advances.
    task automatic step();
        logic [31:0] a, eBE, eWD, mask;
        int unsigned off, n;
        logic rdNew, wrNew, bad, eRE, eWE, eMis;
        #1;
        if (!iRST) resetModel();
        a     = iIouD ? iALUOut : iPC;
        off   = a % 4;
        n     = !iIouD ? 4 : (iFunct3[1:0] == 2'd0) ? 1 : (iFunct3[1:0] == 2'd1) ? 2 : 4;
        bad   = (off % n) != 0;
        rdNew = iRST && iMemRead && !mPrevRd;
        wrNew = iRST && iMemWrite && !mPrevWr;
        eWE   = wrNew && !bad;
        eRE   = rdNew && !wrNew && !bad;
        eMis  = (rdNew || wrNew) && bad;
        eBE   = '0;
        eWD   = '0;
        if (eWE) begin
            eBE = ((32'd1 << n) - 32'd1) << off;
            eWD = (n == 1) ? {4{iRegB[7:0]}} : (n == 2) ? {2{iRegB[15:0]}} : iRegB;
        end
        chk("memAddr", {2'b00, oMemAddr}, a >> 2);
        chk("memRE", {31'd0, oMemRE}, {31'd0, eRE});
        chk("memWE", {31'd0, oMemWE}, {31'd0, eWE});
        chk("memBE", {28'd0, oMemBE}, eBE);
        chk("memWData", oMemWData, eWD);
        chk("misaligned", {31'd0, oMisaligned}, {31'd0, eMis});
        chk("ir", oIR, mIR);
        chk("mdr", oMDR, mMDR);
        chk("busy", {31'd0, oBusy}, {31'd0, mPend});
        sRE = oMemRE; sWE = oMemWE; sMis = oMisaligned; sBusy = oBusy;
        sBE = oMemBE; sWD = oMemWData; sAddr = {2'b00, oMemAddr}; sIR = oIR;

        @(posedge iCLK);
        #1;
        if (sRE) iMemRData = ram[sAddr[7:0]];
        if (sWE) begin
            for (int b = 0; b < 4; b++)
                if (sBE[b]) ram[sAddr[7:0]][8*b +: 8] = sWD[8*b +: 8];
        end
        if (!iRST) begin
            resetModel();
        end else begin
            if (mPend) begin
                if (mPendIR) mIR = mPendWord;
                else         mMDR = mdlLoad(mPendWord, mPendOff, mPendF3, mPendFull);
            end
            mPend = eRE;
            if (eRE) begin
                mPendIR   = iEscreveIR && !iIouD;
                mPendWord = mdl[a[9:2]];
                mPendOff  = off;
                mPendF3   = iFunct3;
                mPendFull = !iIouD;
            end
            if (eWE) begin
                mask = 32'((64'd1 << (8 * n)) - 64'd1) << (8 * off);
                mdl[a[9:2]] = (mdl[a[9:2]] & ~mask) | ((iRegB << (8 * off)) & mask);
            end
            mPrevRd = iMemRead;
            mPrevWr = iMemWrite;
        end
    endtask

    task automatic cyc(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] regb,
                       input logic [2:0] f3, input logic iou, input logic rd, input logic wr,
                       input logic eir, input logic rstN);
        @(negedge iCLK);
        iRST       = rstN;
        iPC        = pc;
        iALUOut    = alu;
        iRegB      = regb;
        iFunct3    = f3;
        iIouD      = iou;
        iMemRead   = rd;
        iMemWrite  = wr;
        iEscreveIR = eir;
        step();
    endtask

    initial begin
        int unsigned kind, hold, idle, pcv;
        logic [2:0] f3;
        logic rd, wr, iou, eir;

        iRST = 1'b0; iPC = '0; iALUOut = '0; iRegB = '0; iFunct3 = '0;
        iIouD = 1'b0; iMemRead = 1'b0; iMemWrite = 1'b0; iEscreveIR = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ram[i] = $urandom;
            mdl[i] = ram[i];
        end
        ram[4] = 32'h00500093;    mdl[4] = ram[4];
        ram[8'h80] = 32'h80FF1234; mdl[8'h80] = ram[8'h80];
        resetModel();

        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_ir", oIR, NOP);
        chk("rst_mdr", oMDR, 32'h0);
        chk("rst_busy", {31'd0, oBusy}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Fetch with PC moving during the hold
        cyc(32'h10, 0, 0, 0, 0, 1, 0, 1, 1);
        chk("fetch_re", {31'd0, sRE}, 32'd1);
        chk("fetch_addr", sAddr, 32'h4);
        cyc(32'h14, 0, 0, 0, 0, 1, 0, 1, 1);
        chk("fetch_re_hold", {31'd0, sRE}, 32'd0);
        chk("fetch_ir", oIR, 32'h00500093);
        cyc(32'h14, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("fetch_ir_keep", oIR, 32'h00500093);

        // LB / LBU from byte 3 of 0x80FF1234
        cyc(32'h14, 32'h203, 0, 3'b000, 1, 1, 0, 0, 1);
        cyc(32'h14, 32'h203, 0, 3'b000, 1, 1, 0, 0, 1);
        chk("lb_mdr", oMDR, 32'hFFFFFF80);
        cyc(32'h14, 32'h203, 0, 3'b000, 1, 0, 0, 0, 1);
        cyc(32'h14, 32'h203, 0, 3'b100, 1, 1, 0, 0, 1);
        cyc(32'h14, 32'h203, 0, 3'b100, 1, 1, 0, 0, 1);
        chk("lbu_mdr", oMDR, 32'h00000080);
        cyc(32'h14, 32'h203, 0, 3'b100, 1, 0, 0, 0, 1);

        // SH to upper half
        cyc(32'h14, 32'h102, 32'h0000ABCD, 3'b001, 1, 0, 1, 0, 1);
        chk("sh_we", {31'd0, sWE}, 32'd1);
        chk("sh_be", {28'd0, sBE}, 32'hC);
        chk("sh_wdata", sWD, 32'hABCDABCD);
        chk("sh_addr", sAddr, 32'h40);
        cyc(32'h14, 32'h102, 32'h0000ABCD, 3'b001, 1, 0, 1, 0, 1);
        chk("sh_we_hold", {31'd0, sWE}, 32'd0);
        cyc(32'h14, 32'h102, 32'h0000ABCD, 3'b001, 1, 0, 0, 0, 1);

        // Misaligned LW
        cyc(32'h14, 32'h101, 0, 3'b010, 1, 1, 0, 0, 1);
        chk("mis_re", {31'd0, sRE}, 32'd0);
        chk("mis_pulse", {31'd0, sMis}, 32'd1);
        cyc(32'h14, 32'h101, 0, 3'b010, 1, 1, 0, 0, 1);
        chk("mis_pulse_end", {31'd0, sMis}, 32'd0);
        chk("mis_mdr_keep", oMDR, 32'h00000080);
        cyc(32'h14, 32'h101, 0, 3'b010, 1, 0, 0, 0, 1);

        // Read and write together: write wins
        cyc(32'h14, 32'h20, 32'h13572468, 3'b010, 1, 1, 1, 0, 1);
        chk("both_we", {31'd0, sWE}, 32'd1);
        chk("both_re", {31'd0, sRE}, 32'd0);
        cyc(32'h14, 32'h20, 32'h13572468, 3'b010, 1, 1, 1, 0, 1);
        cyc(32'h14, 32'h20, 0, 3'b010, 1, 0, 0, 0, 1);
        chk("both_mdr_keep", oMDR, 32'h00000080);

        // Reset during the return cycle of a fetch
        cyc(32'h10, 0, 0, 0, 0, 1, 0, 1, 1);
        chk("rstf_re", {31'd0, sRE}, 32'd1);
        cyc(32'h10, 0, 0, 0, 0, 1, 0, 1, 0);
        chk("rstf_busy", {31'd0, sBusy}, 32'd0);
        chk("rstf_ir", sIR, NOP);
        cyc(32'h10, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("rstf_ir_after", oIR, NOP);
        cyc(32'h10, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("rstf_ir_later", oIR, NOP);

        // Randomized operations
        for (int op = 0; op < 600; op++) begin
            kind = $urandom_range(0, 9);
            hold = $urandom_range(1, 3);
            idle = $urandom_range(0, 2);
            f3   = 3'($urandom_range(0, 7));
            rd = 1'b0; wr = 1'b0; iou = 1'b1; eir = 1'b0;
            case (kind)
                0, 1, 2: begin rd = 1'b1; iou = 1'b0; eir = 1'b1; end
                3, 4:    begin rd = 1'b1; eir = 1'($urandom_range(0, 1)); end
                5, 6:    wr = 1'b1;
                7:       begin rd = 1'b1; wr = 1'b1; end
                8:       begin rd = 1'b1; iou = 1'b0; end
                default: ;
            endcase
            for (int h = 0; h < int'(hold); h++) begin
                pcv = $urandom_range(0, 255) * 4;
                if ($urandom_range(0, 15) == 0) pcv = pcv + $urandom_range(1, 3);
                cyc(pcv, $urandom_range(0, 1023), $urandom, f3, iou, rd, wr, eir,
                    ($urandom_range(0, 40) != 0));
            end
            for (int i = 0; i < int'(idle); i++)
                cyc($urandom_range(0, 255) * 4, $urandom_range(0, 1023), $urandom,
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0, 0, 0, 1);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
